// File: rtl/seg_mux_display.sv
// Multiplexed seven-segment driver with sequential binary-to-BCD (shift-add-3) conversion.
// Optional build macro LEADING_ZERO_BLANK_EN blanks leading zero digits above digit 0.
module seg_mux_display #(
  parameter int DATA_W     = 8,
  parameter int NUM_DIGITS = 3,
  parameter int SCAN_DIV   = 4096
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [DATA_W-1:0]       value,
  input  logic                    load,
  output logic                    busy,
  output logic                    valid,
  output logic [4*NUM_DIGITS-1:0] bcd_out,
  output logic                    ovf,
  output logic [6:0]              segments,
  output logic [NUM_DIGITS-1:0]   digit_en
);

  localparam int BW = 4 * NUM_DIGITS;
  localparam int SW = BW + 4;
  localparam int CW = $clog2(DATA_W + 1);
  localparam int PW = $clog2(SCAN_DIV);
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(SCAN_DIV - 1);
  localparam logic [IW-1:0] IDX_MAX   = IW'(NUM_DIGITS - 1);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_COMMIT} state_t;

  state_t                state_q, state_d;
  logic [DATA_W-1:0]     shift_q, shift_d;
  logic [SW-1:0]         scratch_q, scratch_d, adj;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  lost_q, lost_d;
  logic                  busy_q, busy_d;
  logic                  valid_q, valid_d;
  logic [BW-1:0]         bcd_q, bcd_d;
  logic                  ovf_q, ovf_d;
  logic [PW-1:0]         presc_q, presc_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [NUM_DIGITS-1:0] en_q, en_d;
  logic [6:0]            seg_q, seg_d;
  logic [3:0]            nib;
  logic [BW-1:0]         upper;

  function automatic logic [6:0] seg_decode(input logic [3:0] n);
    case (n)
      4'd0: return 7'h7E;
      4'd1: return 7'h30;
      4'd2: return 7'h6D;
      4'd3: return 7'h79;
      4'd4: return 7'h33;
      4'd5: return 7'h5B;
      4'd6: return 7'h5F;
      4'd7: return 7'h70;
      4'd8: return 7'h7F;
      4'd9: return 7'h7B;
      default: return 7'h00;
    endcase
  endfunction

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    scratch_d = scratch_q;
    cnt_d     = cnt_q;
    lost_d    = lost_q;
    busy_d    = busy_q;
    valid_d   = 1'b0;
    bcd_d     = bcd_q;
    ovf_d     = ovf_q;
    adj       = scratch_q;
    for (int i = 0; i <= NUM_DIGITS; i++) begin
      if (adj[4*i +: 4] >= 4'd5) adj[4*i +: 4] = adj[4*i +: 4] + 4'd3;
    end
    case (state_q)
      S_IDLE: begin
        if (load) begin
          shift_d   = value;
          scratch_d = '0;
          lost_d    = 1'b0;
          cnt_d     = CW'(DATA_W - 1);
          busy_d    = 1'b1;
          state_d   = S_SHIFT;
        end
      end
      S_SHIFT: begin
        {scratch_d, shift_d} = {adj[SW-2:0], shift_q, 1'b0};
        // Any non-zero guard already means overflow; keeping it sticky also
        // covers bits later shifted out or nibble adds that wrap.
        lost_d = lost_q | (adj[SW-1 -: 4] != 4'd0);
        if (cnt_q == '0) state_d = S_COMMIT;
        else             cnt_d   = cnt_q - CW'(1);
      end
      S_COMMIT: begin
        bcd_d   = scratch_q[BW-1:0];
        ovf_d   = lost_q | (scratch_q[SW-1 -: 4] != 4'd0);
        valid_d = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Segments are decoded from next-state values so they change on the same
  // edge as digit_en and as a freshly committed bcd_out.
  always_comb begin
    presc_d = presc_q + PW'(1);
    idx_d   = idx_q;
    if (presc_q == PRESC_MAX) begin
      presc_d = '0;
      idx_d   = (idx_q == IDX_MAX) ? '0 : idx_q + IW'(1);
    end
    en_d  = NUM_DIGITS'(1) << idx_d;
    upper = bcd_d >> (4 * idx_d);
    nib   = upper[3:0];
    seg_d = seg_decode(nib);
`ifdef LEADING_ZERO_BLANK_EN
    if ((idx_d != '0) && (upper == '0)) seg_d = 7'h00;
`endif
    if (ovf_d) seg_d = 7'h01;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      shift_q   <= '0;
      scratch_q <= '0;
      cnt_q     <= '0;
      lost_q    <= 1'b0;
      busy_q    <= 1'b0;
      valid_q   <= 1'b0;
      bcd_q     <= '0;
      ovf_q     <= 1'b0;
      presc_q   <= '0;
      idx_q     <= '0;
      en_q      <= NUM_DIGITS'(1);
      seg_q     <= 7'h7E;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      scratch_q <= scratch_d;
      cnt_q     <= cnt_d;
      lost_q    <= lost_d;
      busy_q    <= busy_d;
      valid_q   <= valid_d;
      bcd_q     <= bcd_d;
      ovf_q     <= ovf_d;
      presc_q   <= presc_d;
      idx_q     <= idx_d;
      en_q      <= en_d;
      seg_q     <= seg_d;
    end
  end

  assign busy     = busy_q;
  assign valid    = valid_q;
  assign bcd_out  = bcd_q;
  assign ovf      = ovf_q;
  assign segments = seg_q;
  assign digit_en = en_q;

endmodule

// File: tb/tb_seg_mux_display.sv
// Bench for seg_mux_display: a 3-digit and a 2-digit instance share stimulus and
// are compared every cycle against an arithmetic model of value, scan slot and decode.
module tb_seg_mux_display;
  localparam int DW = 8;
  localparam int SD = 4;

  logic clk = 1'b0, reset = 1'b1, load = 1'b0;
  logic [7:0] value = 8'd0;
  logic busy3, valid3, ovf3, busy2, valid2, ovf2;
  logic [11:0] bcd3;
  logic [7:0] bcd2;
  logic [6:0] seg3, seg2;
  logic [2:0] en3;
  logic [1:0] en2;

  always #5 clk = ~clk;

  seg_mux_display #(.DATA_W(DW), .NUM_DIGITS(3), .SCAN_DIV(SD)) u3 (
    .clk(clk), .reset(reset), .value(value), .load(load), .busy(busy3), .valid(valid3),
    .bcd_out(bcd3), .ovf(ovf3), .segments(seg3), .digit_en(en3));
  seg_mux_display #(.DATA_W(DW), .NUM_DIGITS(2), .SCAN_DIV(SD)) u2 (
    .clk(clk), .reset(reset), .value(value), .load(load), .busy(busy2), .valid(valid2),
    .bcd_out(bcd2), .ovf(ovf2), .segments(seg2), .digit_en(en2));

  int checks = 0, errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: numbers, not registers.
  logic [6:0] seg_tab [10] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70, 7'h7F, 7'h7B};
  bit live = 0;
  int ticks = 0;
  int left [2], cap [2], disp [2];
  bit movf [2], mvalid [2];

  function automatic int p10(input int n);
    int r = 1;
    for (int i = 0; i < n; i++) r *= 10;
    return r;
  endfunction

  function automatic int nd_of(input int m);
    return (m == 0) ? 3 : 2;
  endfunction

  function automatic int cur_idx(input int m);
    return (ticks / SD) % nd_of(m);
  endfunction

  function automatic logic [31:0] exp_bcd(input int m);
    logic [31:0] r = 0;
    for (int d = 0; d < nd_of(m); d++) r |= 32'((disp[m] / p10(d)) % 10) << (4 * d);
    return r;
  endfunction

  function automatic logic [6:0] exp_seg(input int m);
    int idx = cur_idx(m);
    int hi = disp[m] / p10(idx);
    if (movf[m]) return 7'h01;
`ifdef LEADING_ZERO_BLANK_EN
    if (idx > 0 && hi == 0) return 7'h00;
`endif
    return seg_tab[hi % 10];
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      live = 1;
      ticks = 0;
      for (int m = 0; m < 2; m++) begin
        left[m] = 0; disp[m] = 0; movf[m] = 0; mvalid[m] = 0;
      end
    end else begin
      ticks++;
      for (int m = 0; m < 2; m++) begin
        mvalid[m] = 0;
        if (left[m] > 0) begin
          left[m]--;
          if (left[m] == 0) begin
            movf[m] = cap[m] >= p10(nd_of(m));
            disp[m] = cap[m] % p10(nd_of(m));
            mvalid[m] = 1;
          end
        end else if (load) begin
          cap[m] = value;
          left[m] = DW + 1;
        end
      end
    end
  end

  always @(posedge clk) begin
    #1;
    if (live) begin
      chk("busy3", busy3, left[0] > 0);
      chk("valid3", valid3, mvalid[0]);
      chk("bcd3", bcd3, exp_bcd(0));
      chk("ovf3", ovf3, movf[0]);
      chk("en3", en3, 32'(3'(1) << cur_idx(0)));
      chk("seg3", seg3, exp_seg(0));
      chk("busy2", busy2, left[1] > 0);
      chk("valid2", valid2, mvalid[1]);
      chk("bcd2", bcd2, exp_bcd(1));
      chk("ovf2", ovf2, movf[1]);
      chk("en2", en2, 32'(2'(1) << cur_idx(1)));
      chk("seg2", seg2, exp_seg(1));
    end
  end

  task automatic do_load(input logic [7:0] v);
    @(negedge clk); value = v; load = 1'b1;
    @(negedge clk); load = 1'b0; value = 8'($urandom);
  endtask

  task automatic wait_valid();
    int n = 0;
    while (valid3 !== 1'b1 && n < 30) begin @(posedge clk); #1; n++; end
    chk("wait_valid", n < 30, 1);
  endtask

  task automatic wait_digit(input int m, input int d);
    int n = 0;
    while (((m == 0) ? (en3 !== 3'(1 << d)) : (en2 !== 2'(1 << d))) && n < 20) begin
      @(posedge clk); #1; n++;
    end
    chk("wait_digit", n < 20, 1);
  endtask

  initial begin
    @(negedge clk); @(negedge clk); reset = 1'b0;
    chk("rst_en", en3, 3'b001);
    chk("rst_seg", seg3, 7'h7E);
    chk("rst_busy", busy3, 0);
    chk("rst_bcd", bcd3, 12'h000);
    repeat (4) @(negedge clk); chk("scan4", en3, 3'b010); chk("scan4_seg", seg3, 7'h7E);
    repeat (4) @(negedge clk); chk("scan8", en3, 3'b100);
    repeat (4) @(negedge clk); chk("scan12", en3, 3'b001);

    // 255 with a stray load of 17 during conversion
    @(negedge clk); value = 8'd255; load = 1'b1;
    @(negedge clk); load = 1'b0; value = 8'd0;
    @(negedge clk);
    @(negedge clk); value = 8'd17; load = 1'b1;
    @(negedge clk); load = 1'b0;
    wait_valid();
    chk("bcd255", bcd3, 12'h255); chk("ovf255", ovf3, 0);
    chk("bcd255_2", bcd2, 8'h55); chk("ovf255_2", ovf2, 1);
    wait_digit(0, 0); chk("d0_255", seg3, 7'h5B);
    wait_digit(0, 1); chk("d1_255", seg3, 7'h5B);
    wait_digit(0, 2); chk("d2_255", seg3, 7'h6D);

    do_load(8'd17); wait_valid(); chk("bcd17", bcd3, 12'h017);

    do_load(8'd100); wait_valid(); chk("ovf100", ovf2, 1);
    wait_digit(1, 0); chk("dash0", seg2, 7'h01);
    wait_digit(1, 1); chk("dash1", seg2, 7'h01);
    do_load(8'd99); wait_valid(); chk("bcd99", bcd2, 8'h99); chk("ovf99", ovf2, 0);

    // reset sampled at edge k+4 of a conversion
    do_load(8'd200);
    repeat (3) @(negedge clk); reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    chk("midrst_busy", busy3, 0); chk("midrst_bcd", bcd3, 12'h000); chk("midrst_valid", valid3, 0);
    do_load(8'd123); wait_valid(); chk("bcd123", bcd3, 12'h123);

    do_load(8'd7); wait_valid();
`ifdef LEADING_ZERO_BLANK_EN
    wait_digit(0, 0); chk("blank7_d0", seg3, 7'h70);
    wait_digit(0, 1); chk("blank7_d1", seg3, 7'h00);
    wait_digit(0, 2); chk("blank7_d2", seg3, 7'h00);
    do_load(8'd105); wait_valid();
    wait_digit(0, 0); chk("b105_d0", seg3, 7'h5B);
    wait_digit(0, 1); chk("b105_d1", seg3, 7'h7E);
    wait_digit(0, 2); chk("b105_d2", seg3, 7'h30);
`else
    wait_digit(0, 1); chk("zero7_d1", seg3, 7'h7E);
    wait_digit(0, 2); chk("zero7_d2", seg3, 7'h7E);
`endif

    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      value = 8'($urandom);
      load  = ($urandom_range(0, 3) == 0);
      reset = ($urandom_range(0, 149) == 0);
    end
    @(negedge clk); reset = 1'b0; load = 1'b0;
    repeat (20) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/seg_mux_display.md
Name: seg_mux_display

Overview:
- Multi-digit time-multiplexed seven-segment driver, sitting between a CPU output register and the display pins.
- Accepts a binary value on a load strobe and converts it to BCD sequentially (shift-add-3, one bit per cycle).
- Scans NUM_DIGITS common-cathode digits with a programmable slot length.
- Flags values that do not fit and shows dashes for them.

Parameters:
- DATA_W, 8: width of the binary input value.
- NUM_DIGITS, 3: digits scanned and converted; digit 0 is the ones digit.
- SCAN_DIV, 4096: clk cycles per digit slot; must be >= 2.

Ports:
- clk  in  1  system clock; all state on rising edge.
- reset  in  1  synchronous, active-high reset.
- value  in  DATA_W  binary value to display.
- load  in  1  start a conversion of value (sampled only when busy=0).
- busy  out  1  conversion in progress.
- valid  out  1  one-cycle pulse when bcd_out/ovf are committed.
- bcd_out  out  4*NUM_DIGITS  committed BCD; nibble i = digit i.
- ovf  out  1  committed value >= 10^NUM_DIGITS.
- segments  out  7  {a,b,c,d,e,f,g}, active-high, for the currently enabled digit.
- digit_en  out  NUM_DIGITS  one-hot, active-high digit enable (board inverts to cathodes).

Behaviour:
- Reset values: busy=0, valid=0, bcd_out=0, ovf=0, prescaler=0, scan index=0, digit_en=1 (digit 0), segments=7'h7E ("0").
- Converter FSM: IDLE -> SHIFT -> COMMIT -> IDLE.
  - IDLE: load=1 captures value into a shift register, clears the BCD scratch register, sets busy=1, moves to SHIFT.
  - SHIFT: exactly DATA_W cycles. Each cycle, every scratch nibble >= 5 gets +3, then {scratch, shift} shifts left by 1. Scratch width is 4*NUM_DIGITS plus one guard nibble for overflow detection.
  - COMMIT: one cycle. bcd_out <= low 4*NUM_DIGITS scratch bits; ovf <= (guard nibble != 0) or any carry lost; valid=1 for this cycle only; busy <= 0; return to IDLE.
- Latency: load sampled at edge k -> bcd_out/ovf/valid updated at edge k+DATA_W+1; busy is high for edges k+1..k+DATA_W+1.
- load while busy=1 is ignored; no queueing. load in the same cycle as COMMIT is also ignored. A new load is accepted from the first IDLE cycle.
- value is sampled only at the accepting edge; later changes do not affect the conversion in flight.
- The display always shows the last committed bcd_out. Intermediate scratch values are never displayed.
- Scan:
  - Prescaler counts 0..SCAN_DIV-1 continuously, independent of the converter.
  - When the prescaler wraps, the scan index advances; NUM_DIGITS-1 wraps to 0.
  - digit_en = 1 << index, registered.
  - segments is registered and updated on the same edge as digit_en, so there is no cross-digit glitch.
- Segment decode: 0=7E, 1=30, 2=6D, 3=79, 4=33, 5=5B, 6=5F, 7=70, 8=7F, 9=7B. Nibbles 10-15 decode to 00 (unreachable).
- ovf=1: every digit shows dash 7'h01, overriding blanking.
- reset mid-conversion: FSM returns to IDLE immediately, scratch is discarded, no valid pulse, bcd_out cleared to 0.

Optional Feature:
- Macro LEADING_ZERO_BLANK_EN.
- Defined: digit i>0 shows segments=7'h00 when its nibble and all higher nibbles are 0. Digit 0 is never blanked. digit_en timing is unchanged. ovf dashes take priority over blanking.
- Undefined: all digits are decoded, including leading zeros.

Test Plan:
- Reset, then run 3*SCAN_DIV cycles with SCAN_DIV=4 -> digit_en sequence 001,010,100,001 changing every 4 cycles; segments=7E throughout.
- value=255, load one cycle (DATA_W=8, NUM_DIGITS=3) -> busy high 9 edges; valid pulse at edge k+9; bcd_out=12'h255; ovf=0; digits 0/1/2 show 5B/5B/6D.
- Pulse load with value=17 at cycle k+3 while converting 255 -> load ignored; bcd_out=12'h255; a later load of 17 in IDLE gives 12'h017.
- NUM_DIGITS=2, value=100 -> ovf=1 on commit; every slot segments=01; value=99 next -> ovf=0, bcd_out=8'h99.
- Assert reset at edge k+4 of a conversion -> no valid pulse; busy=0 and bcd_out=0 on the next edge; next load converts normally.
- LEADING_ZERO_BLANK_EN defined, value=7 -> digit 0 shows 70, digits 1 and 2 show 00; value=105 -> shows 5B, 7E, 30 (the inner zero is not blanked).
